// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator: each channel pulses at mul/div of clk_in
// using a phase accumulator, with run-time ratio updates and a settle/lock indicator.
module clk_en_gen #(
   parameter int CHANNELS    = 2,
   parameter int ACC_W       = 16,
   parameter int LOCK_CYCLES = 16,
   parameter int DEF_MUL     = 1,
   parameter int DEF_DIV     = 1,
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk_in,
   input  logic                areset,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [ACC_W-1:0]    cfg_mul,
   input  logic [ACC_W-1:0]    cfg_div,
   output logic                cfg_err,
   output logic [CHANNELS-1:0] ce_out,
   output logic                locked
);

   // state   | meaning
   // SETTLE  | counting undisturbed cycles toward lock
   // LOCKED  | all channels settled, locked=1
   // APPLY   | one cycle: pending ratio is written into its channel
   typedef enum logic [1:0] {SETTLE, LOCKED, APPLY} state_t;

   localparam int CNT_W = $clog2(LOCK_CYCLES) + 1;

   state_t              state;
   logic [CNT_W-1:0]    lock_cnt;
   logic [CH_W-1:0]     pend_ch;
   logic [ACC_W-1:0]    pend_mul;
   logic [ACC_W-1:0]    pend_div;

   logic [ACC_W-1:0]    mul_r  [CHANNELS];
   logic [ACC_W-1:0]    div_r  [CHANNELS];
   logic [ACC_W-1:0]    acc_r  [CHANNELS];
   logic [ACC_W:0]      sum    [CHANNELS];
   logic [ACC_W-1:0]    acc_nx [CHANNELS];
   logic [CHANNELS-1:0] hit;

   logic cfg_bad, cfg_take, accept, reject;

   always_comb begin
      cfg_bad  = (cfg_div == '0) || (cfg_mul > cfg_div) || (32'(cfg_ch) >= CHANNELS);
      cfg_take = cfg_valid && cfg_ready;
      accept   = cfg_take && !cfg_bad;
      reject   = cfg_take && cfg_bad;
   end

   // acc < div always holds, so sum fits in ACC_W+1 bits and the remainder fits in ACC_W
   always_comb begin
      hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         sum[i]    = {1'b0, acc_r[i]} + {1'b0, mul_r[i]};
         hit[i]    = (sum[i] >= {1'b0, div_r[i]});
         acc_nx[i] = hit[i] ? ACC_W'(sum[i] - {1'b0, div_r[i]}) : sum[i][ACC_W-1:0];
      end
   end

   always_ff @(posedge clk_in or posedge areset) begin
      if (areset) begin
         ce_out <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            mul_r[i] <= ACC_W'(DEF_MUL);
            div_r[i] <= ACC_W'(DEF_DIV);
            acc_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (state == APPLY && pend_ch == CH_W'(i)) begin
               mul_r[i]  <= pend_mul;
               div_r[i]  <= pend_div;
               acc_r[i]  <= '0;
               ce_out[i] <= 1'b0;
            end else begin
               acc_r[i]  <= acc_nx[i];
               ce_out[i] <= hit[i];
            end
         end
      end
   end

   always_ff @(posedge clk_in or posedge areset) begin
      if (areset) begin
         state     <= SETTLE;
         lock_cnt  <= '0;
         locked    <= 1'b0;
         cfg_ready <= 1'b0;
         cfg_err   <= 1'b0;
         pend_ch   <= '0;
         pend_mul  <= '0;
         pend_div  <= '0;
      end else begin
         cfg_err <= reject;
         if (accept) begin
            state     <= APPLY;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            pend_ch   <= cfg_ch;
            pend_mul  <= cfg_mul;
            pend_div  <= cfg_div;
         end else begin
            case (state)
               SETTLE: begin
                  cfg_ready <= 1'b1;
                  if (lock_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end else begin
                     lock_cnt <= lock_cnt + 1'b1;
                  end
               end
               LOCKED: begin
                  cfg_ready <= 1'b1;
                  locked    <= 1'b1;
               end
               APPLY: begin
                  state     <= SETTLE;
                  lock_cnt  <= '0;
                  cfg_ready <= 1'b1;
                  locked    <= 1'b0;
               end
               default: begin
                  state    <= SETTLE;
                  lock_cnt <= '0;
                  locked   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Parametrised multi-channel fractional clock-enable generator for the VGA design. It runs from the single board/PLL clock and produces one clock-enable stream per channel at an exact rational rate mul/div of `clk_in`, using a Bresenham-style phase accumulator. For example, a 40 MHz pixel enable from a 100 MHz clock uses mul=2, div=5. Ratios are reprogrammable at run time through a valid/ready port, and a `locked` flag reports when all channels have run undisturbed for a settle period.

## Interface
- `CHANNELS`, default 2: number of independent enable outputs (1..8).
- `ACC_W`, default 16: width of mul, div and each accumulator.
- `LOCK_CYCLES`, default 16: cycles without reconfiguration before `locked` asserts (≥1).
- `DEF_MUL`, default 1: mul loaded into every channel at reset.
- `DEF_DIV`, default 1: div loaded into every channel at reset. Must satisfy 0<DEF_MUL≤DEF_DIV.
- `clk_in`  in  1  sole clock; all logic is rising-edge.
- `areset`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  block can accept config this cycle.
- `cfg_ch`  in  max(1,clog2(CHANNELS))  target channel.
- `cfg_mul`  in  ACC_W  numerator.
- `cfg_div`  in  ACC_W  denominator.
- `cfg_err`  out  1  one-cycle pulse: last request rejected.
- `ce_out`  out  CHANNELS  per-channel registered clock enable.
- `locked`  out  1  all channels settled.

## Operation
- Per channel: registers `mul`, `div`, and `acc` (ACC_W bits). Each cycle, compute sum = acc+mul in ACC_W+1 bits.
  - If sum ≥ div: acc ← sum−div and ce_out[ch] ← 1.
  - Otherwise: acc ← sum and ce_out[ch] ← 0.
- Invariant acc<div holds at all times, so no overflow past ACC_W+1 bits.
- Long-run ce rate is exactly mul/div. mul=div gives ce every cycle. Pulses are spread as evenly as possible.
- FSM states: SETTLE, LOCKED, APPLY.
  - **Reset:** all channels take DEF_MUL/DEF_DIV with acc=0. State is SETTLE with lock counter=0.
  - **SETTLE:** counter increments each cycle. When counter reaches LOCK_CYCLES−1, go to LOCKED.
  - **LOCKED:** locked=1.
  - **APPLY:** entered for exactly one cycle after a valid request is accepted. Then go to SETTLE with counter=0.
- Handshake: a request is accepted when cfg_valid && cfg_ready are both high at an edge. cfg_ready=1 in SETTLE and LOCKED, and 0 in APPLY and during reset.
- A request is rejected when any of these hold: cfg_div==0, cfg_mul>cfg_div, or cfg_ch≥CHANNELS.
  - On rejection: cfg_err=1 for the next cycle and state is unchanged. LOCKED stays LOCKED; a SETTLE count continues.
  - cfg_mul==0 is legal: that channel's ce stays 0.
- Only the targeted channel is affected by APPLY. The other channels keep accumulating with no glitch or phase change.

## Timing
- Reset values while areset is high: ce_out=0, locked=0, cfg_ready=0, cfg_err=0, all acc=0.
- First clock after areset deasserts: the first accumulate occurs and cfg_ready=1.
- With defaults (1/1), ce_out goes all-ones after the 1st edge. locked rises after the LOCK_CYCLES-th edge.
- Valid request accepted at edge E:
  - At E: locked←0, state←APPLY, cfg_ready←0.
  - At E+1: the channel's mul/div are loaded, acc←0, ce_out[ch]←0, state←SETTLE.
  - At E+2: the first accumulate with the new ratio.
  - locked←1 at edge E+1+LOCK_CYCLES if no further request is accepted.
- A request accepted during SETTLE restarts the count. locked stays 0 throughout.
- Rejected request at E: cfg_err=1 during cycle E..E+1 and 0 otherwise. Outputs and ratio registers are untouched.
- areset asserted mid-APPLY or mid-SETTLE: immediate return to reset values. Pending config is lost and all channels revert to DEF ratios.
- cfg_valid held high with the same data re-requests after each APPLY cycle. Every accepted request is applied.

## Test plan
- **Reset/default:** hold areset 3 cycles, release with DEF 1/1 and LOCK_CYCLES=16 → ce_out=all-ones from the 1st edge; locked rises exactly 16 edges after release; cfg_ready=1 after the 1st edge.
- **40 MHz ratio:** program ch0 with mul=2, div=5 → after APPLY, ce_out[0] repeats 0,0,1,0,1 (2 pulses per 5 cycles) over 1000 cycles, count=400 exactly. ch1 is unchanged and shows no glitch.
- **Reject cases:** div=0; mul=6 with div=5; cfg_ch=CHANNELS → each gives a single cfg_err pulse, locked stays 1, ce pattern is unchanged.
- **Relock restart:** accept a config, then another 5 cycles later → locked stays 0, and rises LOCK_CYCLES+1 edges after the second accept.
- **Edge ratios:** mul=0 gives ce constant 0. mul=div=65535 gives ce every cycle. mul=1, div=65535 gives exactly 1 pulse per 65535 cycles and acc never exceeds 65534.
- **Async reset mid-APPLY:** assert areset in the APPLY cycle → all outputs are 0 immediately (no clock edge needed) and the channel resumes DEF ratio after release.
